ca_engine: RTL and testbench
============================

Name: ca_engine

Overview:
Parametrised 1-D elementary cellular-automaton engine: a WIDTH-cell register evolved by an 8-bit Wolfram rule.
Adds selectable boundary modes, a run-for-N-generations controller, and valid/ready backpressure on the generation stream.
Sits between the host loader/control logic and the display/capture sink, and replaces free-running per-cell arrays.

Parameters:
WIDTH, 32, number of cells (>=3)
CNT_W, 16, width of generation count/target

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
rule  in  8  Wolfram rule, latched at start
mode  in  2  boundary: 0 fixed (left/right ports), 1 periodic wrap, 2 reflect, 3 reserved (= 0); latched at start
left  in  1  external neighbour of cell 0 (mode 0), sampled live on each update
right  in  1  external neighbour of cell WIDTH-1 (mode 0), sampled live on each update
load  in  1  load state_in into cells (IDLE only)
state_in  in  WIDTH  load value
start  in  1  begin run (IDLE only)
gen_count  in  CNT_W  target generation, latched at start
halt  in  1  abort run
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal run completion
out  out  WIDTH  current cell state
out_valid  out  1  out holds an unaccepted generation
out_ready  in  1  sink accepts out
gen  out  CNT_W  generation index of out

Behaviour:
- Reset (async, any state): out=0, gen=0, busy=0, done=0, out_valid=0; FSM→IDLE; latched rule/mode/target=0.
- Cell i update: idx={L,C,R}, L=out[i-1], C=out[i], R=out[i+1]; new out[i]=rule_l[idx].
- Edge neighbours: mode 0 → L(0)=left, R(W-1)=right; mode 1 → L(0)=out[W-1], R(W-1)=out[0]; mode 2 → L(0)=out[0], R(W-1)=out[W-1].
- FSM IDLE:
  - load=1 → next cycle out=state_in, gen=0.
  - load=0, start=1 → latch rule/mode/gen_count; RUN next cycle with busy=1, out_valid=1, gen=0 (current out is generation 0).
  - load and start together → load wins, start ignored.
- FSM RUN:
  - Handshake beat = out_valid & out_ready.
  - Beat with gen<target → out=next(out), gen=gen+1, out_valid stays 1 (1 generation/cycle when ready held high).
  - Beat with gen==target → IDLE next cycle, out_valid=0, busy=0, done=1 for exactly one cycle; out/gen retain final values.
  - out_ready=0 → out, gen, out_valid held (no update, no loss).
  - Total beats per run = target+1; gen_count=0 gives one beat (generation 0) then done.
  - halt=1 (priority over beat) → IDLE next cycle, out_valid=0, busy=0, no done; out/gen retain current values.
- load and start ignored while busy; rule/mode input changes ignored while busy.
- gen never exceeds target; no wrap.
- Reset mid-run: immediate abort to reset values, no done.

Test Plan:
- WIDTH=8, mode 0, left=right=0, rule 90, load 8'h10, gen_count=2, ready=1 → beats 8'h10/gen0, 8'h28/gen1, 8'h44/gen2; done one cycle after the third beat; busy falls with it.
- Mode 1, rule 90, load 8'h01, gen_count=1 → beat 2 out=8'h82; repeat with mode 2 → 8'h03; mode 0, left=0 → 8'h02; mode 0, left=1, load 8'h00 → 8'h01.
- Backpressure: same run as scenario 1, out_ready toggled 0/1/0/0/1/1 → identical 3-beat sequence, out/gen stable while ready=0, no extra or missing beats.
- halt asserted with gen=1 and ready=0 → IDLE next cycle, out=8'h28, gen=1, no done; then start accepted again.
- gen_count=0 → one beat of loaded state, done; start held together with load in IDLE → load only, busy stays 0; load while busy → ignored.
- rst pulsed mid-run (async, between clock edges) → out=0, out_valid=0, busy=0, done=0 immediately, not waiting for the next clk edge.

Source files
------------

// File: rtl/ca_engine.sv
// Elementary 1-D cellular-automaton engine: WIDTH cells evolved by an 8-bit Wolfram rule,
// with selectable boundary handling, a run-for-N controller and valid/ready output stream.
module ca_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rule,
    input  logic [1:0]       mode,
    input  logic             left,
    input  logic             right,
    input  logic             load,
    input  logic [WIDTH-1:0] state_in,
    input  logic             start,
    input  logic [CNT_W-1:0] gen_count,
    input  logic             halt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gen
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [7:0]       rule_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] target_q;

    logic             left_nb;
    logic             right_nb;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] next_cells;
    logic             beat;

    always_comb begin
        unique case (mode_q)
            2'd1: begin
                left_nb  = out[WIDTH-1];
                right_nb = out[0];
            end
            2'd2: begin
                left_nb  = out[0];
                right_nb = out[WIDTH-1];
            end
            default: begin
                left_nb  = left;
                right_nb = right;
            end
        endcase
    end

    // ext[i], ext[i+1], ext[i+2] are the L, C, R neighbours of cell i.
    assign ext = {right_nb, out, left_nb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next_cells[i] = rule_q[{ext[i], ext[i+1], ext[i+2]}];
    end

    assign beat = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rule_q    <= '0;
            mode_q    <= '0;
            target_q  <= '0;
            out       <= '0;
            gen       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        out <= state_in;
                        gen <= '0;
                    end else if (start) begin
                        rule_q    <= rule;
                        mode_q    <= mode;
                        target_q  <= gen_count;
                        gen       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (halt) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end else if (beat) begin
                        if (gen < target_q) begin
                            out <= next_cells;
                            gen <= gen + 1'b1;
                        end else begin
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_engine.sv
// Directed bench for ca_engine (WIDTH=8): expected beats are queued at stimulus time and
// popped by a negedge monitor whenever the DUT completes a valid/ready handshake.
module tb_ca_engine;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rule;
    logic [1:0]   mode;
    logic         left;
    logic         right;
    logic         load;
    logic [W-1:0] state_in;
    logic         start;
    logic [C-1:0] gen_count;
    logic         halt;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [C-1:0] gen;

    int checks = 0;
    int errors = 0;

    logic [W+C-1:0] exp_q[$];

    logic         stall_seen = 1'b0;
    logic [W-1:0] stall_out;
    logic [C-1:0] stall_gen;

    ca_engine #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rule      (rule),
        .mode      (mode),
        .left      (left),
        .right     (right),
        .load      (load),
        .state_in  (state_in),
        .start     (start),
        .gen_count (gen_count),
        .halt      (halt),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gen       (gen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference step: L is the lower-index neighbour.
    function automatic logic [W-1:0] ca_step(input logic [W-1:0] s, input logic [7:0] r,
                                             input int m, input logic l, input logic rr);
        logic [W-1:0] n;
        logic         lb, cb, rb;
        for (int i = 0; i < W; i++) begin
            cb = s[i];
            if (i == 0) lb = (m == 1) ? s[W-1] : (m == 2) ? s[0] : l;
            else        lb = s[i-1];
            if (i == W-1) rb = (m == 1) ? s[0] : (m == 2) ? s[W-1] : rr;
            else          rb = s[i+1];
            n[i] = r[{lb, cb, rb}];
        end
        return n;
    endfunction

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        state_in = v;
        tick();
        load = 1'b0;
        check("load_out", 32'(out), 32'(v));
    endtask

    task automatic do_start(input logic [7:0] r, input logic [1:0] m, input logic [C-1:0] n);
        rule = r;
        mode = m;
        gen_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen && !halt) begin
                check("stall_out", 32'(out), 32'(stall_out));
                check("stall_gen", 32'(gen), 32'(stall_gen));
                check("stall_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready && !halt) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(gen), 32'hFFFF_FFFF);
                end else begin
                    logic [W+C-1:0] e;
                    e = exp_q.pop_front();
                    check("beat_out", 32'(out), 32'(e[W+C-1:C]));
                    check("beat_gen", 32'(gen), 32'(e[C-1:0]));
                end
            end
            stall_seen <= out_valid && !out_ready && !halt;
            stall_out  <= out;
            stall_gen  <= gen;
        end
    end

    typedef struct {
        logic [1:0]   m;
        logic         l;
        logic [W-1:0] ld;
        logic [W-1:0] res;
    } mode_case_t;

    initial begin
        mode_case_t mc[4];
        logic [W-1:0] s;
        logic [1:0] bp[6];

        rst = 1'b1;
        rule = '0; mode = '0; left = 1'b0; right = 1'b0;
        load = 1'b0; state_in = '0; start = 1'b0; gen_count = '0;
        halt = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out", 32'(out), 32'd0);
        check("rst_gen", 32'(gen), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Rule 90, fixed zero boundary, three generations.
        do_load(8'h10);
        exp_q.push_back({8'h10, 16'd0});
        exp_q.push_back({8'h28, 16'd1});
        exp_q.push_back({8'h44, 16'd2});
        do_start(8'd90, 2'd0, 16'd2);
        wait_done("basic");
        check("basic_final_out", 32'(out), 32'h44);
        check("basic_final_gen", 32'(gen), 32'd2);

        // Boundary modes.
        mc[0] = '{m: 2'd1, l: 1'b0, ld: 8'h01, res: 8'h82};
        mc[1] = '{m: 2'd2, l: 1'b0, ld: 8'h01, res: 8'h03};
        mc[2] = '{m: 2'd0, l: 1'b0, ld: 8'h01, res: 8'h02};
        mc[3] = '{m: 2'd0, l: 1'b1, ld: 8'h00, res: 8'h01};
        for (int k = 0; k < 4; k++) begin
            left = mc[k].l;
            do_load(mc[k].ld);
            exp_q.push_back({mc[k].ld, 16'd0});
            exp_q.push_back({mc[k].res, 16'd1});
            do_start(8'd90, mc[k].m, 16'd1);
            wait_done("mode");
        end
        left = 1'b0;

        // Backpressure pattern on the basic run.
        bp = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        do_load(8'h10);
        exp_q.push_back({8'h10, 16'd0});
        exp_q.push_back({8'h28, 16'd1});
        exp_q.push_back({8'h44, 16'd2});
        out_ready = 1'b0;
        do_start(8'd90, 2'd0, 16'd2);
        for (int k = 0; k < 6; k++) begin
            out_ready = bp[k][0];
            tick();
        end
        out_ready = 1'b1;
        wait_done("backpressure");

        // Halt at gen 1 while stalled, then restart with a zero-length run.
        do_load(8'h10);
        exp_q.push_back({8'h10, 16'd0});
        do_start(8'd90, 2'd0, 16'd2);
        tick();
        out_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_valid", 32'(out_valid), 32'd0);
        check("halt_done", 32'(done), 32'd0);
        check("halt_out", 32'(out), 32'h28);
        check("halt_gen", 32'(gen), 32'd1);
        check("halt_queue", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        exp_q.push_back({8'h28, 16'd0});
        do_start(8'd90, 2'd0, 16'd0);
        wait_done("zero_run");

        // Load and start together: load wins.
        load = 1'b1; start = 1'b1; state_in = 8'h5A;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldst_busy", 32'(busy), 32'd0);
        check("ldst_valid", 32'(out_valid), 32'd0);
        check("ldst_out", 32'(out), 32'h5A);

        // Load, rule and mode changes ignored while busy.
        out_ready = 1'b0;
        do_start(8'd90, 2'd1, 16'd3);
        load = 1'b1; state_in = 8'hFF; rule = 8'd0; mode = 2'd0; left = 1'b1; right = 1'b1;
        tick();
        load = 1'b0;
        check("busy_load_out", 32'(out), 32'h5A);
        check("busy_load_busy", 32'(busy), 32'd1);
        s = 8'h5A;
        for (int g = 0; g <= 3; g++) begin
            exp_q.push_back({s, 16'(g)});
            s = ca_step(s, 8'd90, 1, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        wait_done("latched");
        left = 1'b0; right = 1'b0;

        // Asynchronous reset mid-run.
        do_load(8'h10);
        out_ready = 1'b0;
        do_start(8'd90, 2'd0, 16'd5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_gen", 32'(gen), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
